clock: RTL and testbench
========================

Name: clock

Overview:
- Digital timekeeping block clocked at 1 Hz, containing three independent engines:
  - a 24-hour time-of-day clock with a manual set mode;
  - an up-counting stopwatch;
  - a settable down-counting timer with a done flag.
- Sits between debounced push-button/mode inputs and display formatting logic.
- All outputs are binary counts, not BCD.

Parameters:
- none (limits fixed: seconds/minutes 0..59, hours 0..23)

Ports:
- clk_1Hz  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- set_time_mode  input  1  1 = main clock paused, manual set enabled
- inc_minutes  input  1  in set mode: minutes+1 per active cycle
- inc_hours  input  1  in set mode: hours+1 per active cycle
- stopwatch_mode  input  1  enables stopwatch command inputs
- start_stopwatch  input  1  start stopwatch
- stop_stopwatch  input  1  pause stopwatch
- reset_stopwatch  input  1  clear stopwatch
- timer_mode  input  1  enables timer command inputs
- set_timer_mode  input  1  with timer_mode: enables timer value increments
- inc_timer_hours  input  1  timer hours+1
- inc_timer_minutes  input  1  timer minutes+1
- inc_timer_seconds  input  1  timer seconds+1
- start_timer  input  1  start countdown
- stop_timer  input  1  pause countdown
- reset_timer  input  1  clear timer
- seconds, minutes  output  6 each  time of day
- hours  output  5  time of day
- stopwatch_seconds, stopwatch_minutes  output  6 each  elapsed time
- stopwatch_hours  output  5  elapsed time
- timer_seconds, timer_minutes  output  6 each  remaining time
- timer_hours  output  5  remaining time
- is_stopwatch_running  output  1  stopwatch running flag
- is_timer_running  output  1  timer running flag
- timer_done  output  1  sticky countdown-complete flag
- carry  output  1  one-cycle day-rollover pulse

Behaviour:
- Reset (async):
  - all counters and all flags = 0;
  - main clock restarts at 00:00:00.
- All outputs are registered.
- Inputs are level-sensitive and sampled every rising edge. A level held N cycles acts N times. There is no edge detection.

Main clock:
- set_time_mode=0:
  - seconds+1 per cycle;
  - seconds 59->0 increments minutes;
  - minutes 59->0 increments hours;
  - hours 23->0 wraps.
- carry = 1 for exactly the cycle following the 23:59:59->00:00:00 transition; 0 otherwise.
- set_time_mode=1:
  - seconds, minutes and hours hold;
  - inc_minutes: minutes+1, wrapping 59->0 with no effect on hours;
  - inc_hours: hours+1, wrapping 23->0;
  - both inputs high: both increment in the same cycle;
  - carry=0.
- inc_minutes and inc_hours are ignored when set_time_mode=0.

Stopwatch:
- Commands act only when stopwatch_mode=1.
- Same-cycle priority: reset_stopwatch > stop_stopwatch > start_stopwatch.
- reset_stopwatch: counts = 0, running = 0.
- stop_stopwatch: running = 0; counts hold.
- start_stopwatch: running = 1; counting resumes from the current value.
- While running: +1 s per cycle with the same cascade as the main clock. Hours wrap 23->0 with no carry.
- Counting continues when stopwatch_mode drops to 0.
- The first increment occurs on the edge after the one that sets running.

Timer:
- Commands act only when timer_mode=1.
- Same-cycle priority: reset_timer > stop_timer > start_timer > increments.
- reset_timer: value = 0, running = 0, done = 0.
- Increments:
  - require set_timer_mode=1 and running=0;
  - seconds and minutes wrap 59->0 independently with no cascade;
  - hours wrap 23->0;
  - any increment clears timer_done.
- start_timer:
  - value nonzero: running = 1, done = 0;
  - value 00:00:00: ignored.
- stop_timer: running = 0; value holds.
- While running: -1 s per cycle with borrow.
  - seconds 0->59 borrows from minutes;
  - minutes 0->59 borrows from hours.
- On the edge where the value becomes 00:00:00: running = 0 and timer_done = 1 on that same edge.
- timer_done is sticky until reset_timer, a successful start_timer, or an increment.
- Countdown continues when timer_mode drops to 0.

Independence:
- The three engines are independent; set_time_mode does not affect the stopwatch or timer.

Test Plan:
- Reset, then 5 cycles -> seconds=5, minutes=0, hours=0, carry=0; all other outputs 0.
- At 00:00:05, set_time_mode=1 with inc_minutes for 1 cycle then inc_hours for 1 cycle, then set_time_mode=0 -> reads 01:01:05 frozen during set; seconds=8 after 3 more cycles.
- Preload 23:59:58 via set mode, run 2 cycles -> 00:00:00 with carry=1 for exactly one cycle. Also: inc_minutes at minutes=59 in set mode -> minutes=0, hours unchanged.
- Stopwatch sequence: stopwatch_mode=1; start for 1 cycle; wait 3; stop for 1 cycle; wait 2; reset_stopwatch.
  - After stop: stopwatch_seconds=4, is_stopwatch_running=0.
  - Value holds 4 during the wait.
  - After reset: 0.
  - Start while stopwatch_mode=0 -> no effect.
- Timer countdown: timer_mode=1, set_timer_mode=1, inc_timer_seconds for 5 cycles -> timer_seconds=5. Then start_timer for 1 cycle.
  - Counts 4,3,2,1,0 on successive cycles.
  - timer_done=1 and is_timer_running=0 by the 5th cycle after start; done stays 1.
- Timer edge cases:
  - start at 00:00:00 -> ignored, done stays 0;
  - preload 00:01:00 -> decrements to 00:00:59;
  - stop mid-count holds the value;
  - reset_timer together with start_timer -> all 0;
  - async reset mid-count -> all 0 immediately.

Source files
------------

// File: rtl/clock.sv
// clock: 1 Hz timekeeping block with three independent engines.
//   - 24-hour time-of-day clock with a manual set mode (carry pulses on day rollover)
//   - up-counting stopwatch (start/stop/reset)
//   - settable down-counting timer with a sticky done flag
// Ports:
//   clk_1Hz, reset           : 1 Hz clock, asynchronous active-high reset
//   set_time_mode, inc_*     : time-of-day set controls
//   stopwatch_mode, *_stopwatch : stopwatch commands (gated by stopwatch_mode)
//   timer_mode, set_timer_mode, inc_timer_*, *_timer : timer commands (gated by timer_mode)
//   seconds/minutes/hours, stopwatch_*, timer_* : binary counts (not BCD), registered
//   is_stopwatch_running, is_timer_running, timer_done, carry : status flags
module clock (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       set_time_mode,
  input  logic       inc_minutes,
  input  logic       inc_hours,
  input  logic       stopwatch_mode,
  input  logic       start_stopwatch,
  input  logic       stop_stopwatch,
  input  logic       reset_stopwatch,
  input  logic       timer_mode,
  input  logic       set_timer_mode,
  input  logic       inc_timer_hours,
  input  logic       inc_timer_minutes,
  input  logic       inc_timer_seconds,
  input  logic       start_timer,
  input  logic       stop_timer,
  input  logic       reset_timer,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic [5:0] stopwatch_seconds,
  output logic [5:0] stopwatch_minutes,
  output logic [4:0] stopwatch_hours,
  output logic [5:0] timer_seconds,
  output logic [5:0] timer_minutes,
  output logic [4:0] timer_hours,
  output logic       is_stopwatch_running,
  output logic       is_timer_running,
  output logic       timer_done,
  output logic       carry
);

  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic       carry_q, carry_d;

  logic [5:0] sw_sec_q, sw_sec_d, sw_min_q, sw_min_d;
  logic [4:0] sw_hr_q, sw_hr_d;
  logic       sw_run_q, sw_run_d;

  logic [5:0] tm_sec_q, tm_sec_d, tm_min_q, tm_min_d;
  logic [4:0] tm_hr_q, tm_hr_d;
  logic       tm_run_q, tm_run_d;
  logic       tm_done_q, tm_done_d;
  logic       tm_nonzero, tm_last, tm_any_inc;

  // Time of day: free-running cascade, or frozen with independent
  // minute/hour bumps while in set mode.
  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    carry_d = 1'b0;
    if (!set_time_mode) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hr_q == 5'd23) begin
            hr_d    = 5'd0;
            carry_d = 1'b1;
          end else begin
            hr_d = hr_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      if (inc_minutes) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      if (inc_hours)   hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
    end
  end

  // Stopwatch: counting follows the registered running flag, so the edge
  // that starts it does not count and the edge that stops it still does.
  always_comb begin
    sw_sec_d = sw_sec_q;
    sw_min_d = sw_min_q;
    sw_hr_d  = sw_hr_q;
    sw_run_d = sw_run_q;
    if (sw_run_q) begin
      if (sw_sec_q == 6'd59) begin
        sw_sec_d = 6'd0;
        if (sw_min_q == 6'd59) begin
          sw_min_d = 6'd0;
          sw_hr_d  = (sw_hr_q == 5'd23) ? 5'd0 : sw_hr_q + 5'd1;
        end else begin
          sw_min_d = sw_min_q + 6'd1;
        end
      end else begin
        sw_sec_d = sw_sec_q + 6'd1;
      end
    end
    if (stopwatch_mode) begin
      if (reset_stopwatch) begin
        sw_sec_d = 6'd0;
        sw_min_d = 6'd0;
        sw_hr_d  = 5'd0;
        sw_run_d = 1'b0;
      end else if (stop_stopwatch) begin
        sw_run_d = 1'b0;
      end else if (start_stopwatch) begin
        sw_run_d = 1'b1;
      end
    end
  end

  assign tm_nonzero = (tm_sec_q != 6'd0) || (tm_min_q != 6'd0) || (tm_hr_q != 5'd0);
  // Running with exactly one second left: this edge lands on zero.
  assign tm_last    = tm_run_q && (tm_hr_q == 5'd0) && (tm_min_q == 6'd0) && (tm_sec_q == 6'd1);
  assign tm_any_inc = inc_timer_hours || inc_timer_minutes || inc_timer_seconds;

  // Timer: borrow countdown while running, commands by priority, and the
  // arrival at zero overrides any same-edge command except reset.
  always_comb begin
    tm_sec_d  = tm_sec_q;
    tm_min_d  = tm_min_q;
    tm_hr_d   = tm_hr_q;
    tm_run_d  = tm_run_q;
    tm_done_d = tm_done_q;
    if (tm_run_q) begin
      if (tm_sec_q != 6'd0) begin
        tm_sec_d = tm_sec_q - 6'd1;
      end else begin
        tm_sec_d = 6'd59;
        if (tm_min_q != 6'd0) begin
          tm_min_d = tm_min_q - 6'd1;
        end else begin
          tm_min_d = 6'd59;
          tm_hr_d  = tm_hr_q - 5'd1;
        end
      end
    end
    if (timer_mode && reset_timer) begin
      tm_sec_d  = 6'd0;
      tm_min_d  = 6'd0;
      tm_hr_d   = 5'd0;
      tm_run_d  = 1'b0;
      tm_done_d = 1'b0;
    end else begin
      if (timer_mode) begin
        if (stop_timer) begin
          tm_run_d = 1'b0;
        end else if (start_timer) begin
          if (tm_nonzero) begin
            tm_run_d  = 1'b1;
            tm_done_d = 1'b0;
          end
        end else if (set_timer_mode && !tm_run_q && tm_any_inc) begin
          if (inc_timer_seconds) tm_sec_d = (tm_sec_q == 6'd59) ? 6'd0 : tm_sec_q + 6'd1;
          if (inc_timer_minutes) tm_min_d = (tm_min_q == 6'd59) ? 6'd0 : tm_min_q + 6'd1;
          if (inc_timer_hours)   tm_hr_d  = (tm_hr_q == 5'd23) ? 5'd0 : tm_hr_q + 5'd1;
          tm_done_d = 1'b0;
        end
      end
      if (tm_last) begin
        tm_run_d  = 1'b0;
        tm_done_d = 1'b1;
      end
    end
  end

  // All engine state registers.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      sec_q     <= 6'd0;
      min_q     <= 6'd0;
      hr_q      <= 5'd0;
      carry_q   <= 1'b0;
      sw_sec_q  <= 6'd0;
      sw_min_q  <= 6'd0;
      sw_hr_q   <= 5'd0;
      sw_run_q  <= 1'b0;
      tm_sec_q  <= 6'd0;
      tm_min_q  <= 6'd0;
      tm_hr_q   <= 5'd0;
      tm_run_q  <= 1'b0;
      tm_done_q <= 1'b0;
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      carry_q   <= carry_d;
      sw_sec_q  <= sw_sec_d;
      sw_min_q  <= sw_min_d;
      sw_hr_q   <= sw_hr_d;
      sw_run_q  <= sw_run_d;
      tm_sec_q  <= tm_sec_d;
      tm_min_q  <= tm_min_d;
      tm_hr_q   <= tm_hr_d;
      tm_run_q  <= tm_run_d;
      tm_done_q <= tm_done_d;
    end
  end

  assign seconds              = sec_q;
  assign minutes              = min_q;
  assign hours                = hr_q;
  assign carry                = carry_q;
  assign stopwatch_seconds    = sw_sec_q;
  assign stopwatch_minutes    = sw_min_q;
  assign stopwatch_hours      = sw_hr_q;
  assign is_stopwatch_running = sw_run_q;
  assign timer_seconds        = tm_sec_q;
  assign timer_minutes        = tm_min_q;
  assign timer_hours          = tm_hr_q;
  assign is_timer_running     = tm_run_q;
  assign timer_done           = tm_done_q;

endmodule

// File: tb/tb_clock.sv
// tb_clock: self-checking bench for the clock block. Directed scenarios
// followed by randomized stimulus, all checked against a model that keeps
// each engine as a plain count of seconds.
module tb_clock;

  logic       clk_1Hz = 1'b0;
  logic       reset = 1'b1;
  logic       set_time_mode, inc_minutes, inc_hours;
  logic       stopwatch_mode, start_stopwatch, stop_stopwatch, reset_stopwatch;
  logic       timer_mode, set_timer_mode, inc_timer_hours, inc_timer_minutes, inc_timer_seconds;
  logic       start_timer, stop_timer, reset_timer;
  logic [5:0] seconds, minutes, stopwatch_seconds, stopwatch_minutes, timer_seconds, timer_minutes;
  logic [4:0] hours, stopwatch_hours, timer_hours;
  logic       is_stopwatch_running, is_timer_running, timer_done, carry;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: each engine as seconds since 00:00:00.
  int tod, sw, tm;
  bit carry_m, sw_run, tm_run, tm_done;

  clock dut (
    .clk_1Hz(clk_1Hz), .reset(reset),
    .set_time_mode(set_time_mode), .inc_minutes(inc_minutes), .inc_hours(inc_hours),
    .stopwatch_mode(stopwatch_mode), .start_stopwatch(start_stopwatch),
    .stop_stopwatch(stop_stopwatch), .reset_stopwatch(reset_stopwatch),
    .timer_mode(timer_mode), .set_timer_mode(set_timer_mode),
    .inc_timer_hours(inc_timer_hours), .inc_timer_minutes(inc_timer_minutes),
    .inc_timer_seconds(inc_timer_seconds), .start_timer(start_timer),
    .stop_timer(stop_timer), .reset_timer(reset_timer),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .stopwatch_seconds(stopwatch_seconds), .stopwatch_minutes(stopwatch_minutes),
    .stopwatch_hours(stopwatch_hours),
    .timer_seconds(timer_seconds), .timer_minutes(timer_minutes), .timer_hours(timer_hours),
    .is_stopwatch_running(is_stopwatch_running), .is_timer_running(is_timer_running),
    .timer_done(timer_done), .carry(carry)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  function automatic logic [54:0] actual_vec();
    return {hours, minutes, seconds, carry,
            stopwatch_hours, stopwatch_minutes, stopwatch_seconds, is_stopwatch_running,
            timer_hours, timer_minutes, timer_seconds, is_timer_running, timer_done};
  endfunction

  function automatic logic [54:0] model_vec();
    logic [4:0] h0, h1, h2;
    logic [5:0] m0, m1, m2, s0, s1, s2;
    h0 = 5'(tod / 3600); m0 = 6'((tod / 60) % 60); s0 = 6'(tod % 60);
    h1 = 5'(sw / 3600);  m1 = 6'((sw / 60) % 60);  s1 = 6'(sw % 60);
    h2 = 5'(tm / 3600);  m2 = 6'((tm / 60) % 60);  s2 = 6'(tm % 60);
    return {h0, m0, s0, carry_m, h1, m1, s1, sw_run, h2, m2, s2, tm_run, tm_done};
  endfunction

  task automatic clear_inputs();
    set_time_mode = 0; inc_minutes = 0; inc_hours = 0;
    stopwatch_mode = 0; start_stopwatch = 0; stop_stopwatch = 0; reset_stopwatch = 0;
    timer_mode = 0; set_timer_mode = 0; inc_timer_hours = 0; inc_timer_minutes = 0;
    inc_timer_seconds = 0; start_timer = 0; stop_timer = 0; reset_timer = 0;
  endtask

  task automatic model_clear();
    tod = 0; sw = 0; tm = 0;
    carry_m = 0; sw_run = 0; tm_run = 0; tm_done = 0;
  endtask

  // Advance the model by one rising edge using the sampled inputs.
  task automatic model_step();
    int h, m, s, nsw, nt;
    bit nrun, nr, nd;
    if (!set_time_mode) begin
      carry_m = (tod == 86399);
      tod = (tod + 1) % 86400;
    end else begin
      carry_m = 0;
      h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
      if (inc_minutes) m = (m + 1) % 60;
      if (inc_hours) h = (h + 1) % 24;
      tod = h * 3600 + m * 60 + s;
    end
    nsw = sw_run ? (sw + 1) % 86400 : sw;
    nrun = sw_run;
    if (stopwatch_mode) begin
      if (reset_stopwatch) begin nsw = 0; nrun = 0; end
      else if (stop_stopwatch) nrun = 0;
      else if (start_stopwatch) nrun = 1;
    end
    if (timer_mode && reset_timer) begin
      nt = 0; nr = 0; nd = 0;
    end else begin
      nt = tm_run ? tm - 1 : tm;
      nr = tm_run; nd = tm_done;
      if (timer_mode) begin
        if (stop_timer) nr = 0;
        else if (start_timer) begin
          if (tm != 0) begin nr = 1; nd = 0; end
        end else if (set_timer_mode && !tm_run &&
                     (inc_timer_hours || inc_timer_minutes || inc_timer_seconds)) begin
          h = tm / 3600; m = (tm / 60) % 60; s = tm % 60;
          if (inc_timer_seconds) s = (s + 1) % 60;
          if (inc_timer_minutes) m = (m + 1) % 60;
          if (inc_timer_hours) h = (h + 1) % 24;
          nt = h * 3600 + m * 60 + s;
          nd = 0;
        end
      end
      if (tm_run && nt == 0) begin nr = 0; nd = 1; end
    end
    sw = nsw; sw_run = nrun; tm = nt; tm_run = nr; tm_done = nd;
  endtask

  task automatic tick();
    @(posedge clk_1Hz);
    model_step();
    #1;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    model_clear();
    #2;
    tests_run++;
    if (actual_vec() !== 55'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %h want 0", actual_vec());
    end
    @(posedge clk_1Hz); #1 reset = 0;
    applyStimulus(5);
    tests_run++;
    if (seconds !== 6'd5 || minutes !== 6'd0 || hours !== 5'd0 || carry !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL run_5s: got %0d:%0d:%0d c%0d want 0:0:5 c0", hours, minutes, seconds, carry);
    end
    tests_run++;
    if (actual_vec() !== model_vec()) begin
      tests_failed++;
      $display("[TB] FAIL others_zero: got %h want %h", actual_vec(), model_vec());
    end
  endtask

  task automatic test_set_time();
    set_time_mode = 1; inc_minutes = 1;
    tick();
    tests_run++;
    if (seconds !== 6'd5 || minutes !== 6'd1 || hours !== 5'd0) begin
      tests_failed++;
      $display("[TB] FAIL set_min: got %0d:%0d:%0d want 0:1:5", hours, minutes, seconds);
    end
    inc_minutes = 0; inc_hours = 1;
    tick();
    inc_hours = 0;
    tests_run++;
    if (seconds !== 6'd5 || minutes !== 6'd1 || hours !== 5'd1 || carry !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL set_hr: got %0d:%0d:%0d want 1:1:5", hours, minutes, seconds);
    end
    set_time_mode = 0;
    applyStimulus(3);
    tests_run++;
    if (seconds !== 6'd8 || minutes !== 6'd1 || hours !== 5'd1) begin
      tests_failed++;
      $display("[TB] FAIL resume: got %0d:%0d:%0d want 1:1:8", hours, minutes, seconds);
    end
  endtask

  task automatic test_rollover();
    int h, m;
    while (tod % 60 != 58) tick();
    h = tod / 3600; m = (tod / 60) % 60;
    set_time_mode = 1;
    inc_hours = 1;
    for (int i = h; i < 23; i++) tick();
    inc_hours = 0; inc_minutes = 1;
    for (int i = m; i < 59; i++) tick();
    inc_minutes = 0;
    tests_run++;
    if (hours !== 5'd23 || minutes !== 6'd59 || seconds !== 6'd58) begin
      tests_failed++;
      $display("[TB] FAIL preload: got %0d:%0d:%0d want 23:59:58", hours, minutes, seconds);
    end
    set_time_mode = 0;
    tick();
    tests_run++;
    if (seconds !== 6'd59 || carry !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL pre_wrap: got s%0d c%0d want s59 c0", seconds, carry);
    end
    tick();
    tests_run++;
    if (hours !== 5'd0 || minutes !== 6'd0 || seconds !== 6'd0 || carry !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL day_wrap: got %0d:%0d:%0d c%0d want 0:0:0 c1", hours, minutes, seconds, carry);
    end
    tick();
    tests_run++;
    if (seconds !== 6'd1 || carry !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL carry_pulse: got s%0d c%0d want s1 c0", seconds, carry);
    end
    set_time_mode = 1; inc_minutes = 1;
    applyStimulus(59);
    tests_run++;
    if (minutes !== 6'd59 || hours !== 5'd0) begin
      tests_failed++;
      $display("[TB] FAIL min_to_59: got %0d:%0d want 0:59", hours, minutes);
    end
    tick();
    inc_minutes = 0;
    tests_run++;
    if (minutes !== 6'd0 || hours !== 5'd0 || carry !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL min_wrap: got %0d:%0d c%0d want 0:0 c0", hours, minutes, carry);
    end
    set_time_mode = 0;
  endtask

  task automatic test_stopwatch();
    stopwatch_mode = 1; start_stopwatch = 1;
    tick();
    start_stopwatch = 0;
    applyStimulus(3);
    stop_stopwatch = 1;
    tick();
    stop_stopwatch = 0;
    tests_run++;
    if (stopwatch_seconds !== 6'd4 || is_stopwatch_running !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sw_stop: got s%0d r%0d want s4 r0", stopwatch_seconds, is_stopwatch_running);
    end
    applyStimulus(2);
    tests_run++;
    if (stopwatch_seconds !== 6'd4) begin
      tests_failed++;
      $display("[TB] FAIL sw_hold: got %0d want 4", stopwatch_seconds);
    end
    reset_stopwatch = 1;
    tick();
    reset_stopwatch = 0;
    tests_run++;
    if (stopwatch_seconds !== 6'd0 || is_stopwatch_running !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sw_reset: got s%0d r%0d want s0 r0", stopwatch_seconds, is_stopwatch_running);
    end
    stopwatch_mode = 0; start_stopwatch = 1;
    tick();
    start_stopwatch = 0;
    tick();
    tests_run++;
    if (stopwatch_seconds !== 6'd0 || is_stopwatch_running !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sw_gated: got s%0d r%0d want s0 r0", stopwatch_seconds, is_stopwatch_running);
    end
  endtask

  task automatic test_timer_countdown();
    timer_mode = 1; set_timer_mode = 1; inc_timer_seconds = 1;
    applyStimulus(5);
    inc_timer_seconds = 0; set_timer_mode = 0;
    tests_run++;
    if (timer_seconds !== 6'd5) begin
      tests_failed++;
      $display("[TB] FAIL tm_load: got %0d want 5", timer_seconds);
    end
    start_timer = 1;
    tick();
    start_timer = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      tests_run++;
      if (timer_seconds !== 6'(5 - i) || timer_minutes !== 6'd0 || timer_hours !== 5'd0) begin
        tests_failed++;
        $display("[TB] FAIL tm_count%0d: got %0d want %0d", i, timer_seconds, 5 - i);
      end
    end
    tests_run++;
    if (timer_done !== 1'b1 || is_timer_running !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL tm_done: got d%0d r%0d want d1 r0", timer_done, is_timer_running);
    end
    applyStimulus(2);
    tests_run++;
    if (timer_done !== 1'b1 || timer_seconds !== 6'd0) begin
      tests_failed++;
      $display("[TB] FAIL tm_sticky: got d%0d s%0d want d1 s0", timer_done, timer_seconds);
    end
  endtask

  task automatic test_timer_edges();
    logic [5:0] held;
    reset_timer = 1;
    tick();
    reset_timer = 0;
    start_timer = 1;
    tick();
    start_timer = 0;
    tests_run++;
    if (is_timer_running !== 1'b0 || timer_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL tm_zero_start: got r%0d d%0d want r0 d0", is_timer_running, timer_done);
    end
    set_timer_mode = 1; inc_timer_minutes = 1;
    tick();
    inc_timer_minutes = 0; set_timer_mode = 0;
    start_timer = 1;
    tick();
    start_timer = 0;
    tick();
    tests_run++;
    if (timer_hours !== 5'd0 || timer_minutes !== 6'd0 || timer_seconds !== 6'd59) begin
      tests_failed++;
      $display("[TB] FAIL tm_borrow: got %0d:%0d:%0d want 0:0:59", timer_hours, timer_minutes, timer_seconds);
    end
    applyStimulus(2);
    stop_timer = 1;
    tick();
    stop_timer = 0;
    held = 6'(tm % 60);
    applyStimulus(3);
    tests_run++;
    if (timer_seconds !== held || is_timer_running !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL tm_stop_hold: got s%0d r%0d want s%0d r0", timer_seconds, is_timer_running, held);
    end
    reset_timer = 1; start_timer = 1;
    tick();
    reset_timer = 0; start_timer = 0;
    tests_run++;
    if (timer_seconds !== 6'd0 || timer_minutes !== 6'd0 || timer_hours !== 5'd0 ||
        is_timer_running !== 1'b0 || timer_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL tm_reset_start: got %0d:%0d:%0d r%0d d%0d want all 0",
               timer_hours, timer_minutes, timer_seconds, is_timer_running, timer_done);
    end
    set_timer_mode = 1; inc_timer_hours = 1;
    tick();
    inc_timer_hours = 0; set_timer_mode = 0; start_timer = 1;
    tick();
    start_timer = 0;
    applyStimulus(2);
    #2 reset = 1;
    #1;
    model_clear();
    tests_run++;
    if (actual_vec() !== 55'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got %h want 0", actual_vec());
    end
    clear_inputs();
    @(posedge clk_1Hz); #1 reset = 0;
  endtask

  // Randomized stimulus; every cycle the full output set is checked.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_time_mode     = ($urandom_range(7) == 0);
      inc_minutes       = $urandom_range(1);
      inc_hours         = $urandom_range(1);
      stopwatch_mode    = $urandom_range(1);
      start_stopwatch   = ($urandom_range(7) == 0);
      stop_stopwatch    = ($urandom_range(15) == 0);
      reset_stopwatch   = ($urandom_range(39) == 0);
      timer_mode        = $urandom_range(1);
      set_timer_mode    = $urandom_range(1);
      inc_timer_hours   = ($urandom_range(2) == 0);
      inc_timer_minutes = ($urandom_range(2) == 0);
      inc_timer_seconds = ($urandom_range(2) == 0);
      start_timer       = ($urandom_range(7) == 0);
      stop_timer        = ($urandom_range(15) == 0);
      reset_timer       = ($urandom_range(39) == 0);
      tick();
      tests_run++;
      if (actual_vec() !== model_vec()) begin
        tests_failed++;
        $display("[TB] FAIL random_cycle%0d: got %h want %h", i, actual_vec(), model_vec());
      end
    end
    clear_inputs();
  endtask

  task automatic checkOutput();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_rollover();
    test_stopwatch();
    test_timer_countdown();
    test_timer_edges();
    test_random();
    checkOutput();
    $finish;
  end

endmodule
